// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_port
// Purpose  : Router input unit for a 2D-mesh NoC. Buffers incoming flits in
//            a DEPTH-entry FIFO, computes the XY route once per packet from
//            its head flit, holds that route for the whole packet and offers
//            flits to the switch allocator / crossbar with a val/gnt
//            handshake. Every dequeued flit returns a one-cycle credit pulse
//            upstream.
//
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            X_address  - this router's X coordinate (static)
//            Y_address  - this router's Y coordinate (static)
//            data_in    - incoming flit
//            val_in     - data_in valid; written when FIFO not full
//            full       - FIFO full (registered)
//            ret_in     - credit pulse, one per dequeued flit (registered)
//            data_out   - flit at FIFO head (0 while FIFO empty)
//            val_out    - data_out valid toward the crossbar
//            gnt        - grant from the switch allocator
//            route      - output port of current packet (0=L,1=N,2=S,3=E,4=W)
//            used       - FIFO occupancy
//            err        - sticky error flag (only with NOC_IP_ERR_EN)
//
// Options  : NOC_IP_ERR_EN - when defined, adds the sticky 'err' output, set
//            by a write attempt while full or by a stray body/tail flit
//            discarded while idle.
//
// Revision : 1.0 - initial release
// ============================================================================
module noc_input_port #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COORD_W-1:0]         X_address,
    input  logic [COORD_W-1:0]         Y_address,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       val_in,
    output logic                       full,
    output logic                       ret_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       val_out,
    input  logic                       gnt,
    output logic [2:0]                 route,
    output logic [$clog2(DEPTH):0]     used
`ifdef NOC_IP_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    localparam logic [2:0] C_PORT_L = 3'd0;
    localparam logic [2:0] C_PORT_N = 3'd1;
    localparam logic [2:0] C_PORT_S = 3'd2;
    localparam logic [2:0] C_PORT_E = 3'd3;
    localparam logic [2:0] C_PORT_W = 3'd4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              full_q,   full_d;
    logic              ret_q,    ret_d;
    logic [2:0]        route_q,  route_d;
    state_t            state_q,  state_d;
    logic              err_q,    err_d;

    logic [DATA_W-1:0] head_flit;
    logic              empty;
    logic              wr_en;
    logic              grant_pop;
    logic              stray_pop;
    logic              pop;

    // XY dimension-order routing: resolve X first, then Y, else local.
    function automatic logic [2:0] xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] here_x,
        input logic [COORD_W-1:0] here_y
    );
        if (dest_x > here_x)      return C_PORT_E;
        else if (dest_x < here_x) return C_PORT_W;
        else if (dest_y > here_y) return C_PORT_N;
        else if (dest_y < here_y) return C_PORT_S;
        else                      return C_PORT_L;
    endfunction

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        head_flit = mem_q[rd_ptr_q];
        empty     = (count_q == '0);
        // full is sampled before any pop this cycle, so a write on a
        // full FIFO is dropped even if a pop frees a slot at the same edge.
        wr_en     = val_in && !full_q;

        state_d   = state_q;
        route_d   = route_q;
        val_out   = 1'b0;
        grant_pop = 1'b0;
        stray_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    // Type bit DATA_W-2 is set for head (01) and single (11).
                    if (head_flit[DATA_W-2]) begin
                        route_d = xy_route(head_flit[2*COORD_W-1:COORD_W],
                                           head_flit[COORD_W-1:0],
                                           X_address, Y_address);
                        state_d = ACTIVE;
                    end else begin
                        // Body/tail with no open packet: discard, but still
                        // return its credit so upstream stays in sync.
                        stray_pop = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                val_out = !empty;
                if (!empty && gnt) begin
                    grant_pop = 1'b1;
                    // Type bit DATA_W-1 is set for tail (10) and single (11).
                    if (head_flit[DATA_W-1]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pop      = grant_pop || stray_pop;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        full_d   = (count_d == C_DEPTH);
        ret_d    = pop;
        err_d    = err_q || (val_in && full_q) || stray_pop;

        data_out = empty ? '0 : head_flit;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ret_q    <= 1'b0;
            route_q  <= C_PORT_L;
            state_q  <= IDLE;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ret_q    <= ret_d;
            route_q  <= route_d;
            state_q  <= state_d;
            err_q    <= err_d;
        end
    end

    // Flit storage is not reset; data_out is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign full   = full_q;
    assign ret_in = ret_q;
    assign route  = route_q;
    assign used   = count_q;

`ifdef NOC_IP_ERR_EN
    assign err = err_q;
`else
    // Without the error port the flag has no observer.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
`default_nettype wire
